// File: rtl/forward_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit_pkg
// Shared definitions for the EX-stage forwarding / load-use hazard control:
//   - forward-select codes consumed by the EX-stage operand muxes
//   - FSM state encoding for the stall controller
//   - layout of one shadow pipeline stage {valid, rd, regwrite, memread}
// No ports (package).
// -----------------------------------------------------------------------------
package forward_hazard_unit_pkg;

  // Operand mux select codes
  localparam logic [1:0] FWD_REG   = 2'b00;  // register file value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM pipeline data
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB pipeline data
  localparam logic [1:0] FWD_ZERO  = 2'b11;  // constant zero (r0)

  // Stall controller states
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // Width of the destination-register field held in a shadow stage; the
  // top-level REG_AW parameter defaults to this value and must agree with it.
  localparam int STAGE_RD_W = 5;

  // One shadow pipeline stage
  typedef struct packed {
    logic                  valid;
    logic [STAGE_RD_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } stage_t;

  localparam stage_t STAGE_EMPTY = '0;

endpackage

// File: rtl/forward_hazard_unit_if.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit_if
// Bundles the ID-stage instruction fields going into the hazard unit and the
// forwarding / stall controls coming back out.
//   master : drives ID fields + flush, observes selects, stall controls, count
//   slave  : the hazard unit itself
// Parameters: REG_AW (register address width), CNT_W (stall counter width).
// -----------------------------------------------------------------------------
interface forward_hazard_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regwrite;
  logic              id_memread;
  logic              flush;

  logic [0:1]        ForwardA;
  logic [0:1]        ForwardB;
  logic              pc_write;
  logic              ifid_write;
  logic              idex_bubble;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, flush,
    input  ForwardA, ForwardB, pc_write, ifid_write, idex_bubble, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regwrite, id_memread, flush,
    output ForwardA, ForwardB, pc_write, ifid_write, idex_bubble, stall_cnt
  );

endinterface

// File: rtl/forward_hazard_unit_fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select
// Combinational priority encoder producing the forward-select code for one
// source operand of the instruction currently in ID (registered by the parent
// so it lines up with that instruction once it reaches EX).
// Ports:
//   kill        - no forwarding at all (hazard, flush or empty ID slot)
//   use_src     - ID instruction actually reads this operand
//   src         - source register number
//   ex_valid/ex_rd/ex_regwrite    - shadow EX stage (will be in MEM)
//   mem_valid/mem_rd/mem_regwrite - shadow MEM stage (will be in WB)
//   sel         - forward-select code
// -----------------------------------------------------------------------------
module fwd_select
  import forward_hazard_unit_pkg::*;
(
  input  logic                  kill,
  input  logic                  use_src,
  input  logic [STAGE_RD_W-1:0] src,
  input  logic                  ex_valid,
  input  logic [STAGE_RD_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  mem_valid,
  input  logic [STAGE_RD_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  output logic [1:0]            sel
);

  // The EX-stage match is checked before MEM so the youngest producer wins.
  // A matching r0 never reaches the producer checks, so r0 never forwards.
  always_comb begin
    sel = FWD_REG;
    if (kill || !use_src) begin
      sel = FWD_REG;
    end else if (src == '0) begin
      sel = FWD_ZERO;
    end else if (ex_valid && ex_regwrite && (ex_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_valid && mem_regwrite && (mem_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// forward_hazard_unit
// Control side of the EX-stage forwarding muxes for a 5-stage pipeline.
// Keeps a shadow copy of destination-register info for EX, MEM and WB and
// produces:
//   ForwardA/ForwardB - registered operand selects for the instruction in EX
//   pc_write, ifid_write, idex_bubble - combinational load-use stall controls
//   stall_cnt - saturating count of load-use stall events
// Ports: clk, rst (synchronous, active high), bus (forward_hazard_unit_if.slave)
// Parameters: REG_AW register address width, CNT_W stall counter width.
// -----------------------------------------------------------------------------
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int REG_AW = STAGE_RD_W,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  forward_hazard_unit_if.slave bus
);

  stage_t           ex_q;
  stage_t           mem_q;
  stage_t           wb_q;
  stage_t           id_stage;
  logic [0:0]       state_q;
  logic [1:0]       fwd_a_q;
  logic [1:0]       fwd_b_q;
  logic [1:0]       fwd_a_d;
  logic [1:0]       fwd_b_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic             luh;
  logic             kill;
  logic             rs1_hit;
  logic             rs2_hit;

  // Load-use hazard: a load sits in EX and the ID instruction reads its
  // destination. A flush kills the ID instruction, so it can never stall.
  always_comb begin
    rs1_hit = bus.id_use_rs1 && (ex_q.rd == bus.id_rs1);
    rs2_hit = bus.id_use_rs2 && (ex_q.rd == bus.id_rs2);
    luh = bus.id_valid && !bus.flush &&
          ex_q.valid && ex_q.memread && (ex_q.rd != '0) &&
          (rs1_hit || rs2_hit);
    kill = luh || bus.flush || !bus.id_valid;
  end

  always_comb begin
    id_stage.valid    = bus.id_valid;
    id_stage.rd       = bus.id_rd;
    id_stage.regwrite = bus.id_regwrite;
    id_stage.memread  = bus.id_memread;
  end

  fwd_select u_fwd_a (
    .kill         (kill),
    .use_src      (bus.id_use_rs1),
    .src          (bus.id_rs1),
    .ex_valid     (ex_q.valid),
    .ex_rd        (ex_q.rd),
    .ex_regwrite  (ex_q.regwrite),
    .mem_valid    (mem_q.valid),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .sel          (fwd_a_d)
  );

  fwd_select u_fwd_b (
    .kill         (kill),
    .use_src      (bus.id_use_rs2),
    .src          (bus.id_rs2),
    .ex_valid     (ex_q.valid),
    .ex_rd        (ex_q.rd),
    .ex_regwrite  (ex_q.regwrite),
    .mem_valid    (mem_q.valid),
    .mem_rd       (mem_q.rd),
    .mem_regwrite (mem_q.regwrite),
    .sel          (fwd_b_d)
  );

  // Shadow pipeline, registered selects and stall FSM. The FSM only needs
  // one STALL cycle: the bubble placed in EX means luh cannot reassert on
  // the very next cycle. The counter steps once per RUN->STALL entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= STAGE_EMPTY;
      mem_q       <= STAGE_EMPTY;
      wb_q        <= STAGE_EMPTY;
      state_q     <= ST_RUN;
      fwd_a_q     <= FWD_REG;
      fwd_b_q     <= FWD_REG;
      stall_cnt_q <= '0;
    end else begin
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      ex_q    <= (luh || bus.flush) ? STAGE_EMPTY : id_stage;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      case (state_q)
        ST_RUN: begin
          if (luh) begin
            state_q <= ST_STALL;
            if (stall_cnt_q != '1) begin
              stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_STALL: state_q <= ST_RUN;
        default:  state_q <= ST_RUN;
      endcase
    end
  end

  assign bus.ForwardA    = fwd_a_q;
  assign bus.ForwardB    = fwd_b_q;
  assign bus.pc_write    = !luh;
  assign bus.ifid_write  = !luh;
  assign bus.idex_bubble = luh || bus.flush;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_forward_hazard_unit
// Directed bench for forward_hazard_unit. Inputs change 1 time unit after a
// rising edge; combinational outputs are checked before the next edge and
// registered outputs 1 time unit after the edge that loads them.
// -----------------------------------------------------------------------------
module tb_forward_hazard_unit;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  forward_hazard_unit_if #(.REG_AW(5), .CNT_W(16)) bus ();

  forward_hazard_unit #(.REG_AW(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against the sequence ever stalling out.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic valid,
                               input logic [4:0] rs1, input logic use1,
                               input logic [4:0] rs2, input logic use2,
                               input logic [4:0] rd,  input logic regwrite,
                               input logic memread,   input logic flush);
    bus.id_valid    = valid;
    bus.id_rs1      = rs1;
    bus.id_use_rs1  = use1;
    bus.id_rs2      = rs2;
    bus.id_use_rs2  = use2;
    bus.id_rd       = rd;
    bus.id_regwrite = regwrite;
    bus.id_memread  = memread;
    bus.flush       = flush;
    #1;
  endtask

  task automatic applyNop();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
      $error("[TB] %s observed %0h required %0h", tag, observed, expected);
    end
  endtask

  task automatic drain();
    applyNop();
    repeat (3) stepClock();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Reset held two cycles with a live instruction in ID
    rst = 1'b1;
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0);
    stepClock();
    stepClock();
    checkOutput("rst_fwdA", 32'(bus.ForwardA), 32'h0);
    checkOutput("rst_fwdB", 32'(bus.ForwardB), 32'h0);
    checkOutput("rst_pc_write", 32'(bus.pc_write), 32'h1);
    checkOutput("rst_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("rst_idex_bubble", 32'(bus.idex_bubble), 32'h0);
    checkOutput("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    rst = 1'b0;
    drain();

    // ALU chain: ADD r3 <- r1,r2 ; SUB r6 <- r3,r4 ; OR r8 <- r5,r3
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("alu_add_fwdA", 32'(bus.ForwardA), 32'h0);
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    checkOutput("alu_sub_pc_write", 32'(bus.pc_write), 32'h1);
    stepClock();
    checkOutput("alu_sub_fwdA", 32'(bus.ForwardA), 32'h1);
    checkOutput("alu_sub_fwdB", 32'(bus.ForwardB), 32'h0);
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("alu_or_fwdB", 32'(bus.ForwardB), 32'h2);
    checkOutput("alu_or_fwdA", 32'(bus.ForwardA), 32'h0);
    drain();

    // Load-use: LW r5 ; ADD r7 <- r6,r5
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd6, 1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    checkOutput("lu_pc_write", 32'(bus.pc_write), 32'h0);
    checkOutput("lu_ifid_write", 32'(bus.ifid_write), 32'h0);
    checkOutput("lu_idex_bubble", 32'(bus.idex_bubble), 32'h1);
    stepClock();
    checkOutput("lu_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    checkOutput("lu_bubble_fwdB", 32'(bus.ForwardB), 32'h0);
    checkOutput("lu_retry_pc_write", 32'(bus.pc_write), 32'h1);
    checkOutput("lu_retry_idex_bubble", 32'(bus.idex_bubble), 32'h0);
    stepClock();
    checkOutput("lu_add_fwdB", 32'(bus.ForwardB), 32'h2);
    checkOutput("lu_add_fwdA", 32'(bus.ForwardA), 32'h0);
    checkOutput("lu_add_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    drain();

    // Priority: two writers of r7, then a reader of r7
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("prio_fwdA", 32'(bus.ForwardA), 32'h1);
    checkOutput("prio_fwdB", 32'(bus.ForwardB), 32'h0);
    drain();

    // Register zero: ALU writer of r0, reader; LW r0, reader
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("r0_fwdA", 32'(bus.ForwardA), 32'h3);
    checkOutput("r0_fwdB", 32'(bus.ForwardB), 32'h3);
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
    checkOutput("r0_lw_pc_write", 32'(bus.pc_write), 32'h1);
    checkOutput("r0_lw_idex_bubble", 32'(bus.idex_bubble), 32'h0);
    stepClock();
    checkOutput("r0_lw_fwdA", 32'(bus.ForwardA), 32'h3);
    checkOutput("r0_lw_fwdB", 32'(bus.ForwardB), 32'h3);
    checkOutput("r0_lw_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    drain();

    // Flush beats load-use: LW r2 ; reader of r2 with flush
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_pc_write", 32'(bus.pc_write), 32'h1);
    checkOutput("flush_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("flush_idex_bubble", 32'(bus.idex_bubble), 32'h1);
    stepClock();
    checkOutput("flush_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    checkOutput("flush_fwdA", 32'(bus.ForwardA), 32'h0);
    drain();

    // Reset while stalled: LW r4 ; reader of r4 ; reset in STALL
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    checkOutput("rs_lu_pc_write", 32'(bus.pc_write), 32'h0);
    stepClock();
    checkOutput("rs_lu_stall_cnt", 32'(bus.stall_cnt), 32'h2);
    rst = 1'b1;
    stepClock();
    rst = 1'b0;
    checkOutput("rs_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    checkOutput("rs_fwdA", 32'(bus.ForwardA), 32'h0);
    checkOutput("rs_pc_write", 32'(bus.pc_write), 32'h1);
    checkOutput("rs_ifid_write", 32'(bus.ifid_write), 32'h1);
    checkOutput("rs_idex_bubble", 32'(bus.idex_bubble), 32'h0);
    // A fresh load-use must be counted, which only happens from RUN
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
    stepClock();
    checkOutput("rs_run_stall_cnt", 32'(bus.stall_cnt), 32'h1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
